// File: rtl/hall_call_dispatcher.sv
// Hall-call latch and one-at-a-time cost-based assignment to two cars.
// Define DISPATCH_REASSIGN_EN to return unserved calls after CLAIM_TIMEOUT cycles.
module hall_call_dispatcher #(
  parameter int CLAIM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] newHallButton,
  input  logic [2:0]  currentFloor1,
  input  logic [2:0]  currentFloor2,
  input  logic [1:0]  currentDirection1,
  input  logic [1:0]  currentDirection2,
  input  logic [11:0] servedHall1,
  input  logic [11:0] servedHall2,
  output logic [11:0] assignedHall1,
  output logic [11:0] assignedHall2,
  output logic [11:0] pendingHall,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PICK,
    S_COST,
    S_GRANT
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [11:0] r_pend;
  logic [11:0] r_asg1;
  logic [11:0] r_asg2;
  logic [3:0]  r_ptr;
  logic [3:0]  r_sel;
  logic [3:0]  r_cost1;
  logic [3:0]  r_cost2;

  logic [11:0] w_srv;
  logic [11:0] w_all;
  logic [11:0] w_gmask;
  logic [11:0] w_tmo;
  logic [3:0]  w_pick;
  logic [3:0]  w_cflr;
  logic [3:0]  w_c1;
  logic [3:0]  w_c2;
  logic [3:0]  w_pop1;
  logic [3:0]  w_pop2;
  logic        w_gnt;
  logic        w_win2;

  function automatic logic [3:0] f_cost(
    input logic [3:0] fl,
    input logic [2:0] car,
    input logic [1:0] dir
  );
    logic [3:0] cf;
    logic [3:0] c;
    cf = {1'b0, car};
    c  = (fl >= cf) ? fl - cf : cf - fl;
    if ((dir == 2'b01) && (fl < cf))
      c = c + 4'd8;
    if ((dir == 2'b10) && (fl > cf))
      c = c + 4'd8;
    return c;
  endfunction

  function automatic logic [3:0] f_pop(
    input logic [11:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 12; i++)
      n = n + {3'b0, v[i]};
    return n;
  endfunction

  assign w_srv = servedHall1 | servedHall2;
  assign w_all = r_pend | r_asg1 | r_asg2;

  always_comb begin
    int idx;
    logic found;
    w_pick = r_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < 12; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= 12)
        idx = idx - 12;
      if (!found && r_pend[idx]) begin
        w_pick = 4'(idx);
        found  = 1'b1;
      end
    end
  end

  // Up calls sit at sel+1, down calls at sel-4
  assign w_cflr = (r_sel < 4'd6) ? r_sel + 4'd1 : r_sel - 4'd4;
  assign w_c1   = f_cost(w_cflr, currentFloor1, currentDirection1);
  assign w_c2   = f_cost(w_cflr, currentFloor2, currentDirection2);
  assign w_pop1 = f_pop(r_asg1);
  assign w_pop2 = f_pop(r_asg2);

  assign w_win2 = (r_cost2 < r_cost1) ||
                  ((r_cost2 == r_cost1) && (w_pop2 < w_pop1));

  assign w_gnt   = (r_state == S_GRANT) && r_pend[r_sel] && !w_srv[r_sel];
  assign w_gmask = w_gnt ? (12'b1 << r_sel) : 12'b0;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (|r_pend) w_nxt = S_PICK;
      S_PICK:  w_nxt = S_COST;
      S_COST:  w_nxt = S_GRANT;
      S_GRANT: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cost1 <= '0;
      r_cost2 <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_PICK)
        r_sel <= w_pick;
      if (r_state == S_COST) begin
        r_cost1 <= w_c1;
        r_cost2 <= w_c2;
      end
      if (w_gnt)
        r_ptr <= (r_sel == 4'd11) ? 4'd0 : r_sel + 4'd1;
    end
  end

  // Service clears everything; grant never coincides with a served bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_asg1 <= '0;
      r_asg2 <= '0;
    end else begin
      r_pend <= (r_pend | (newHallButton & ~w_all) | w_tmo)
                & ~w_srv & ~w_gmask;
      r_asg1 <= (r_asg1 | (w_win2 ? 12'b0 : w_gmask))
                & ~w_srv & ~w_tmo;
      r_asg2 <= (r_asg2 | (w_win2 ? w_gmask : 12'b0))
                & ~w_srv & ~w_tmo;
    end
  end

`ifdef DISPATCH_REASSIGN_EN
  localparam logic [7:0] LP_LIM = 8'(CLAIM_TIMEOUT - 1);

  logic [7:0]  r_age [12];
  logic [11:0] w_own;

  assign w_own = r_asg1 | r_asg2;

  always_comb begin
    w_tmo = '0;
    for (int i = 0; i < 12; i++)
      w_tmo[i] = w_own[i] && (r_age[i] == LP_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 12; i++)
        r_age[i] <= '0;
    end else begin
      for (int i = 0; i < 12; i++)
        r_age[i] <= (w_own[i] && !w_srv[i] && !w_tmo[i]) ?
                    r_age[i] + 8'd1 : 8'd0;
    end
  end
`else
  assign w_tmo = '0;
`endif

  assign assignedHall1 = r_asg1;
  assign assignedHall2 = r_asg2;
  assign pendingHall   = r_pend;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed bench for hall_call_dispatcher with a queue of expected values.
module tb_hall_call_dispatcher;

  logic        clk;
  logic        reset;
  logic [11:0] newHallButton;
  logic [2:0]  currentFloor1;
  logic [2:0]  currentFloor2;
  logic [1:0]  currentDirection1;
  logic [1:0]  currentDirection2;
  logic [11:0] servedHall1;
  logic [11:0] servedHall2;
  logic [11:0] assignedHall1;
  logic [11:0] assignedHall2;
  logic [11:0] pendingHall;
  logic        busy;

  int n_chk;
  int n_fail;
  logic [11:0] exp_q[$];

  hall_call_dispatcher #(.CLAIM_TIMEOUT(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .newHallButton     (newHallButton),
    .currentFloor1     (currentFloor1),
    .currentFloor2     (currentFloor2),
    .currentDirection1 (currentDirection1),
    .currentDirection2 (currentDirection2),
    .servedHall1       (servedHall1),
    .servedHall2       (servedHall2),
    .assignedHall1     (assignedHall1),
    .assignedHall2     (assignedHall2),
    .pendingHall       (pendingHall),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [11:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [11:0] obs);
    logic [11:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty, got %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s got %h want %h", tag, obs, e);
      end
    end
  endtask

  task automatic press(input logic [11:0] m);
    newHallButton = m;
    tick();
    newHallButton = '0;
  endtask

  task automatic cars(input logic [2:0] f1, input logic [1:0] d1,
                      input logic [2:0] f2, input logic [1:0] d2);
    currentFloor1     = f1;
    currentDirection1 = d1;
    currentFloor2     = f2;
    currentDirection2 = d2;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    newHallButton = '0;
    servedHall1   = '0;
    servedHall2   = '0;
    push(12'h000); push(12'h000); push(12'h000); push(12'h000);
    ticks(2);
    chk("rst_asg1", assignedHall1);
    chk("rst_asg2", assignedHall2);
    chk("rst_pend", pendingHall);
    chk("rst_busy", {11'b0, busy});
    reset = 1'b1;
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cars(3'd1, 2'b00, 3'd7, 2'b00);
    do_reset();

    // Single call, car1 nearest
    push(12'h001); push(12'h000);
    press(12'h001);
    chk("t1_pend", pendingHall);
    chk("t1_busy0", {11'b0, busy});
    push(12'h001);
    tick();
    chk("t1_busy1", {11'b0, busy});
    push(12'h001); push(12'h000); push(12'h000); push(12'h000);
    ticks(3);
    chk("t1_asg1", assignedHall1);
    chk("t1_asg2", assignedHall2);
    chk("t1_pend2", pendingHall);
    chk("t1_busy2", {11'b0, busy});

    // Full tie then popcount tie-break
    do_reset();
    cars(3'd4, 2'b00, 3'd4, 2'b00);
    push(12'h008); push(12'h000);
    press(12'h008);
    ticks(4);
    chk("t2_asg1a", assignedHall1);
    chk("t2_asg2a", assignedHall2);
    push(12'h008); push(12'h010);
    press(12'h010);
    ticks(4);
    chk("t2_asg1b", assignedHall1);
    chk("t2_asg2b", assignedHall2);

    // Direction penalties
    do_reset();
    cars(3'd2, 2'b01, 3'd6, 2'b00);
    push(12'h040); push(12'h000);
    press(12'h040);
    ticks(4);
    chk("t3_asg1", assignedHall1);
    chk("t3_asg2", assignedHall2);
    cars(3'd3, 2'b01, 3'd7, 2'b00);
    push(12'h002);
    press(12'h002);
    ticks(4);
    chk("t3_up_away", assignedHall2);
    cars(3'd3, 2'b10, 3'd7, 2'b00);
    push(12'h102); push(12'h040);
    press(12'h100);
    ticks(4);
    chk("t3_dn_away", assignedHall2);
    chk("t3_asg1b", assignedHall1);

    // All twelve calls at once, with a duplicate burst mid-way
    do_reset();
    cars(3'd1, 2'b00, 3'd7, 2'b00);
    push(12'hFFF);
    press(12'hFFF);
    chk("t4_pend0", pendingHall);
    for (int t = 1; t <= 49; t++) begin
      logic [11:0] m;
      int k;
      k = (t / 4 > 12) ? 12 : t / 4;
      m = 12'((1 << k) - 1);
      push({11'b0, (t <= 48) && (t % 4 != 0)});
      push(m);
      push(~m);
      if (t == 10)
        newHallButton = 12'hFFF;
      tick();
      newHallButton = '0;
      chk("t4_busy", {11'b0, busy});
      chk("t4_union", assignedHall1 | assignedHall2);
      chk("t4_pend", pendingHall);
    end
    push(12'h000);
    chk("t4_disj", assignedHall1 & assignedHall2);

    // Service clears regardless of owner
    push(12'hF00); push(12'h000);
    servedHall1 = 12'h00F;
    servedHall2 = 12'h0F0;
    tick();
    servedHall1 = '0;
    servedHall2 = '0;
    chk("t4_srv", assignedHall1 | assignedHall2);
    chk("t4_srv_pend", pendingHall);

    // Service during COST aborts the grant, pointer stays
    do_reset();
    cars(3'd1, 2'b00, 3'd7, 2'b00);
    press(12'h020);
    ticks(2);
    push(12'h000); push(12'h000); push(12'h001);
    servedHall2 = 12'h020;
    tick();
    servedHall2 = '0;
    chk("t5_pend", pendingHall);
    chk("t5_asg", assignedHall1 | assignedHall2);
    chk("t5_busy", {11'b0, busy});
    push(12'h000); push(12'h000); push(12'h000);
    tick();
    chk("t5_asg2", assignedHall1 | assignedHall2);
    chk("t5_pend2", pendingHall);
    chk("t5_busy2", {11'b0, busy});
    push(12'h001); push(12'h080);
    press(12'h081);
    ticks(4);
    chk("t5_ptr", assignedHall1 | assignedHall2);
    chk("t5_ptr_pend", pendingHall);

    // Unserved call: timeout return or permanent ownership
    do_reset();
    cars(3'd1, 2'b00, 3'd7, 2'b00);
    push(12'h004); push(12'h000);
    press(12'h004);
    ticks(4);
    chk("t6_asg1", assignedHall1);
    chk("t6_pend", pendingHall);
`ifdef DISPATCH_REASSIGN_EN
    push(12'h004); push(12'h000);
    ticks(7);
    chk("t6_hold", assignedHall1);
    chk("t6_hold_pend", pendingHall);
    push(12'h000); push(12'h004);
    tick();
    chk("t6_ret_asg", assignedHall1);
    chk("t6_ret_pend", pendingHall);
    push(12'h004); push(12'h000);
    ticks(4);
    chk("t6_reasg", assignedHall1);
    chk("t6_reasg_pend", pendingHall);
`else
    push(12'h004); push(12'h000);
    ticks(16);
    chk("t6_keep", assignedHall1);
    chk("t6_keep_pend", pendingHall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
